// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer behind the rename stage.
// Instructions enter at the tail in program order. Completion reports may
// arrive out of order. The head retires in order, at most one per cycle, and
// the retirement RAT supplies the physical tag that the retiring instruction
// supersedes so rename can return it to its free pool.
//
// Handshake: an allocation is accepted at a posedge where alloc_valid and
// alloc_ready are both high. alloc_ready depends only on registered state, so
// rename may treat ~alloc_ready as a stall with no combinational loop. The
// retire outputs are single-cycle pulses and are not back-pressured.
`timescale 1ns/1ps
module reorder_buffer #(
    parameter int NUM_REG        = 32,
    parameter int NUM_REG_LOG2   = $clog2(NUM_REG),
    parameter int NUM_TAGS       = 64,
    parameter int NUM_TAGS_LOG2  = $clog2(NUM_TAGS),
    parameter int ROB_DEPTH      = 16,
    parameter int ROB_DEPTH_LOG2 = $clog2(ROB_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_valid,
    input  logic [NUM_REG_LOG2-1:0]   alloc_rd,
    input  logic [NUM_TAGS_LOG2-1:0]  alloc_tag,
    output logic                      alloc_ready,
    output logic [ROB_DEPTH_LOG2-1:0] alloc_idx,
    input  logic                      complete_valid,
    input  logic [ROB_DEPTH_LOG2-1:0] complete_idx,
    input  logic                      retire_stall,
    output logic                      commit_valid,
    output logic [NUM_REG_LOG2-1:0]   commit_rd,
    output logic                      retire_valid,
    output logic [NUM_TAGS_LOG2-1:0]  retire_tag,
    output logic [ROB_DEPTH_LOG2:0]   count
);

    localparam logic [ROB_DEPTH_LOG2:0] FULL_COUNT = (ROB_DEPTH_LOG2+1)'(ROB_DEPTH);

    // Per-entry status bits (reset) and payload (no reset needed, guarded by valid)
    logic [ROB_DEPTH-1:0]       ent_valid;
    logic [ROB_DEPTH-1:0]       ent_done;
    logic [NUM_REG_LOG2-1:0]    ent_rd  [ROB_DEPTH];
    logic [NUM_TAGS_LOG2-1:0]   ent_tag [ROB_DEPTH];

    // Architectural-to-physical mapping as of the last retired instruction
    logic [NUM_TAGS_LOG2-1:0]   rrat [NUM_REG];

    logic [ROB_DEPTH_LOG2-1:0]  head;
    logic [ROB_DEPTH_LOG2-1:0]  tail;

    logic                       alloc_fire;
    logic                       retire_fire;
    logic                       complete_fire;
    logic [NUM_REG_LOG2-1:0]    head_rd;
    logic [NUM_TAGS_LOG2-1:0]   head_tag;

    assign alloc_ready = (count != FULL_COUNT);
    assign alloc_idx   = tail;

    // Fire decisions for this edge, all from registered state plus inputs
    always_comb begin
        alloc_fire    = alloc_valid & alloc_ready;
        retire_fire   = ent_valid[head] & ent_done[head] & ~retire_stall;
        complete_fire = complete_valid & ent_valid[complete_idx];
        head_rd       = ent_rd[head];
        head_tag      = ent_tag[head];
    end

    // Entry status: completion marks done, allocation opens, retirement closes
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid <= '0;
            ent_done  <= '0;
        end else begin
            if (complete_fire) begin
                ent_done[complete_idx] <= 1'b1;
            end
            if (alloc_fire) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
            end
            // Retirement last: head != tail whenever both fire, so no overlap
            if (retire_fire) begin
                ent_valid[head] <= 1'b0;
                ent_done[head]  <= 1'b0;
            end
        end
    end

    // Entry payload written on allocation
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_rd[tail]  <= alloc_rd;
            ent_tag[tail] <= alloc_tag;
        end
    end

    // Head/tail pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + 1'b1;
            end
            if (retire_fire) begin
                head <= head + 1'b1;
            end
            count <= count + (ROB_DEPTH_LOG2+1)'(alloc_fire) - (ROB_DEPTH_LOG2+1)'(retire_fire);
        end
    end

    // Retirement RAT: starts as identity to match rename's reset mapping
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REG; i++) begin
                rrat[i] <= NUM_TAGS_LOG2'(i);
            end
        end else if (retire_fire && (head_rd != '0)) begin
            rrat[head_rd] <= head_tag;
        end
    end

    // Registered commit/free pulses; all-zero when nothing retires
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            retire_valid <= 1'b0;
            retire_tag   <= '0;
        end else begin
            commit_valid <= retire_fire;
            commit_rd    <= retire_fire ? head_rd : '0;
            retire_valid <= retire_fire && (head_rd != '0);
            retire_tag   <= (retire_fire && (head_rd != '0)) ? rrat[head_rd] : '0;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios followed by random traffic.
// The reference model is a queue of in-flight instructions plus an array
// RAT; each predicted retirement is queued as {retire_valid, rd, tag} and a
// negedge monitor checks it against the DUT pulses.
`timescale 1ns/1ps
module tb_reorder_buffer;

    localparam int W = 1 + 5 + 6;

    logic       clk;
    logic       rst;
    logic       alloc_valid;
    logic [4:0] alloc_rd;
    logic [5:0] alloc_tag;
    logic       alloc_ready;
    logic [3:0] alloc_idx;
    logic       complete_valid;
    logic [3:0] complete_idx;
    logic       retire_stall;
    logic       commit_valid;
    logic [4:0] commit_rd;
    logic       retire_valid;
    logic [5:0] retire_tag;
    logic [4:0] count;

    reorder_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_rd       (alloc_rd),
        .alloc_tag      (alloc_tag),
        .alloc_ready    (alloc_ready),
        .alloc_idx      (alloc_idx),
        .complete_valid (complete_valid),
        .complete_idx   (complete_idx),
        .retire_stall   (retire_stall),
        .commit_valid   (commit_valid),
        .commit_rd      (commit_rd),
        .retire_valid   (retire_valid),
        .retire_tag     (retire_tag),
        .count          (count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct {
        int rd;
        int tag;
        bit done;
    } ent_t;

    ent_t           mq[$];
    int             m_rrat[32];
    int             m_head;
    int             m_tail;
    bit             exp_now;
    bit             mon_en;
    logic [W-1:0]   exp_q[$];
    int             total;
    int             bad;

    function automatic void model_update(input bit r, input bit av, input int rd, input int tg,
                                         input bit cv, input int ci, input bit st);
        bit ret;
        bit alc;
        int pos;
        ent_t e;
        if (r) begin
            mq.delete();
            m_head  = 0;
            m_tail  = 0;
            exp_now = 0;
            for (int i = 0; i < 32; i++) m_rrat[i] = i;
            return;
        end
        ret = (mq.size() > 0) && mq[0].done && !st;
        alc = av && (mq.size() < 16);
        if (cv) begin
            pos = ((ci - m_head) % 16 + 16) % 16;
            if (pos < mq.size()) mq[pos].done = 1'b1;
        end
        exp_now = ret;
        if (ret) begin
            bit rv;
            int rt;
            e  = mq.pop_front();
            rv = (e.rd != 0);
            rt = rv ? m_rrat[e.rd] : 0;
            if (rv) m_rrat[e.rd] = e.tag;
            exp_q.push_back({rv, 5'(e.rd), 6'(rt)});
            m_head = (m_head + 1) % 16;
        end
        if (alc) begin
            e.rd   = rd;
            e.tag  = tg;
            e.done = 1'b0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % 16;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input bit r, input bit av, input int rd, input int tg,
                        input bit cv, input int ci, input bit st);
        rst            = r;
        alloc_valid    = av;
        alloc_rd       = 5'(rd);
        alloc_tag      = 6'(tg);
        complete_valid = cv;
        complete_idx   = 4'(ci);
        retire_stall   = st;
        @(posedge clk);
        model_update(r, av, rd, tg, cv, ci, st);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc(input int rd, input int tg);
        step(0, 1, rd, tg, 0, 0, 0);
    endtask

    task automatic complete(input int idx);
        step(0, 0, 0, 0, 1, idx, 0);
    endtask

    // Complete every outstanding entry and wait (bounded) for the buffer to empty
    task automatic drain();
        int n;
        n = mq.size();
        for (int p = 0; p < n; p++) begin
            if (p < mq.size() && !mq[p].done) complete((m_head + p) % 16);
        end
        for (int i = 0; i < 40 && mq.size() != 0; i++) idle(1);
        idle(2);
    endtask

    // ---------------- scoreboard / monitor ----------------
    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", int'(count), mq.size());
            chk("alloc_ready", int'(alloc_ready), int'(mq.size() != 16));
            chk("alloc_idx", int'(alloc_idx), m_tail);
            chk("commit_valid", int'(commit_valid), int'(exp_now));
            if (commit_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL commit_unexpected: got commit rd=%0d, required none", commit_rd);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("commit_rd", int'(commit_rd), int'(e[10:6]));
                    chk("retire_valid", int'(retire_valid), int'(e[11]));
                    chk("retire_tag", int'(retire_tag), int'(e[5:0]));
                end
            end else begin
                chk("idle_commit_rd", int'(commit_rd), 0);
                chk("idle_retire_valid", int'(retire_valid), 0);
                chk("idle_retire_tag", int'(retire_tag), 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        total = 0;
        bad   = 0;
        mon_en = 1'b0;
        exp_now = 1'b0;
        m_head = 0;
        m_tail = 0;
        for (int i = 0; i < 32; i++) m_rrat[i] = i;
        do_reset();
        mon_en = 1'b1;

        // Basic retire and rrat update
        idle(2);
        alloc(5, 32);
        complete(0);
        idle(2);
        alloc(5, 33);
        complete(1);
        idle(3);

        // Out-of-order completion
        alloc(1, 40);
        alloc(2, 41);
        alloc(3, 42);
        complete(4);
        complete(3);
        idle(2);
        complete(2);
        idle(5);

        // Full and wrap, from a fresh reset so the tail starts at 0
        do_reset();
        for (int i = 0; i < 16; i++) alloc(i + 1, 10 + i);
        alloc(20, 50);                   // refused: full
        complete(0);
        alloc(21, 51);                   // refused even though head retires here
        idle(1);
        alloc(22, 52);                   // lands at idx 0
        drain();

        // rd = 0 leaves the rrat alone
        alloc(0, 0);
        complete(m_tail == 0 ? 15 : m_tail - 1);
        idle(2);
        alloc(0, 9);
        complete(m_tail == 0 ? 15 : m_tail - 1);
        idle(3);

        // retire_stall holds a completed head; completion to an invalid idx is ignored
        alloc(9, 60);
        complete(m_tail == 0 ? 15 : m_tail - 1);
        step(0, 0, 0, 0, 1, (m_tail + 5) % 16, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, (m_tail + 7) % 16, 1);
        idle(3);

        // Reset with live entries, then rrat must be identity again
        for (int i = 0; i < 5; i++) alloc(7, 20 + i);
        complete(m_head);
        do_reset();
        idle(1);
        alloc(7, 44);
        complete(0);
        idle(3);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            bit av;
            bit cv;
            bit st;
            bit r;
            int ci;
            av = ($urandom_range(0, 99) < 60);
            st = ($urandom_range(0, 99) < 20);
            r  = ($urandom_range(0, 499) == 0);
            cv = 1'b0;
            ci = 0;
            if (mq.size() > 0 && $urandom_range(0, 99) < 70) begin
                cv = 1'b1;
                ci = (m_head + int'($urandom_range(0, mq.size() - 1))) % 16;
            end else if ($urandom_range(0, 99) < 15) begin
                cv = 1'b1;
                ci = int'($urandom_range(0, 15));
                if (ci == m_tail) cv = 1'b0;  // never complete the entry being allocated
            end
            step(r, av, int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), cv, ci, st);
        end
        drain();

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL exp_q_leftover: got %0d pending, required 0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
